// File: rtl/vector_mac_pipe.sv
// Pipelined signed fixed-point dot product with multi-beat accumulation.
// Define VECTOR_MAC_SAT_EN for saturating arithmetic instead of wrapping.
module vector_mac_pipe #(
    parameter int DATA_W = 16,
    parameter int FRAC   = 12,
    parameter int LEN    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LEN*DATA_W-1:0] in_a,
    input  logic [LEN*DATA_W-1:0] in_b,
    input  logic                  in_first,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data
);
    localparam int PW = 2 * DATA_W;

    logic                     adv;
    logic signed [PW-1:0]     prod    [LEN];
    logic signed [DATA_W-1:0] lane    [LEN];
    logic signed [DATA_W-1:0] s1_lane [LEN];
    logic                     s1_valid;
    logic                     s1_first;
    logic                     s1_last;
    logic signed [DATA_W-1:0] sum;
    logic signed [DATA_W-1:0] s2_sum;
    logic                     s2_valid;
    logic                     s2_first;
    logic                     s2_last;
    logic signed [DATA_W-1:0] acc;
    logic signed [DATA_W-1:0] base;
    logic signed [DATA_W-1:0] nxt;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

`ifdef VECTOR_MAC_SAT_EN
    localparam int SW = DATA_W + $clog2(LEN) + 1;
    localparam int HW = PW - FRAC - DATA_W + 1;
    localparam logic signed [SW-1:0] MAX_W =
        {{(SW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [SW-1:0] MIN_W =
        {{(SW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic signed [DATA_W-1:0] MAX_D = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] MIN_D = {1'b1, {(DATA_W-1){1'b0}}};

    function automatic logic signed [DATA_W-1:0] clamp(
        input logic signed [SW-1:0] v
    );
        if (v > MAX_W) return MAX_D;
        if (v < MIN_W) return MIN_D;
        return DATA_W'(v);
    endfunction

    logic signed [SW-1:0] sum_w;
`endif

    // Lane multiply; the shift floors toward -inf before narrowing.
    always_comb begin
        for (int i = 0; i < LEN; i++) begin
            prod[i] = PW'($signed(in_a[i*DATA_W +: DATA_W]))
                    * PW'($signed(in_b[i*DATA_W +: DATA_W]));
`ifdef VECTOR_MAC_SAT_EN
            if (prod[i][PW-1 -: HW] == {HW{prod[i][PW-1]}})
                lane[i] = DATA_W'(prod[i] >>> FRAC);
            else
                lane[i] = prod[i][PW-1] ? MIN_D : MAX_D;
`else
            lane[i] = DATA_W'(prod[i] >>> FRAC);
`endif
        end
    end

`ifdef VECTOR_MAC_SAT_EN
    always_comb begin
        sum_w = '0;
        for (int i = 0; i < LEN; i++)
            sum_w = sum_w + SW'(s1_lane[i]);
        sum = clamp(sum_w);
    end
`else
    always_comb begin
        sum = '0;
        for (int i = 0; i < LEN; i++)
            sum = sum + s1_lane[i];
    end
`endif

    assign base = s2_first ? '0 : acc;

`ifdef VECTOR_MAC_SAT_EN
    assign nxt = clamp(SW'(base) + SW'(s2_sum));
`else
    assign nxt = base + s2_sum;
`endif

    // Whole pipeline advances together; a held result freezes every stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_first  <= 1'b0;
            s1_last   <= 1'b0;
            for (int i = 0; i < LEN; i++)
                s1_lane[i] <= '0;
            s2_valid  <= 1'b0;
            s2_first  <= 1'b0;
            s2_last   <= 1'b0;
            s2_sum    <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (adv) begin
            s1_valid <= in_valid;
            s1_first <= in_first;
            s1_last  <= in_last;
            for (int i = 0; i < LEN; i++)
                s1_lane[i] <= lane[i];
            s2_valid  <= s1_valid;
            s2_first  <= s1_first;
            s2_last   <= s1_last;
            s2_sum    <= sum;
            out_valid <= s2_valid && s2_last;
            if (s2_valid) begin
                if (s2_last) begin
                    out_data <= nxt;
                    acc      <= '0;
                end else begin
                    acc <= nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_vector_mac_pipe.sv
// Bench for vector_mac_pipe: directed cases plus randomized beats
// checked against an arithmetic reference model.
module tb_vector_mac_pipe;
    localparam int W  = 16;
    localparam int FR = 12;
    localparam int L  = 3;

`ifdef VECTOR_MAC_SAT_EN
    localparam logic [31:0] OVF_EXP = 'h7FFF;
`else
    localparam logic [31:0] OVF_EXP = 'hA000;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [L*W-1:0] in_a;
    logic [L*W-1:0] in_b;
    logic         in_first;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    int total = 0;
    int bad   = 0;
    int m_acc = 0;
    logic [W-1:0] exp_q [$];

    vector_mac_pipe #(.DATA_W(W), .FRAC(FR), .LEN(L)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_a(in_a),
        .in_b(in_b),
        .in_first(in_first),
        .in_last(in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reduce an integer to the DATA_W result range (wrap or clamp).
    function automatic int fix(input int v);
        int m;
        m = 1 << W;
`ifdef VECTOR_MAC_SAT_EN
        if (v > m / 2 - 1) return m / 2 - 1;
        if (v < -(m / 2)) return -(m / 2);
        return v;
`else
        return ((v + m / 2) % m + m) % m - m / 2;
`endif
    endfunction

    function automatic void model_beat(input logic [L*W-1:0] va,
                                       input logic [L*W-1:0] vb,
                                       input logic f, input logic l);
        int s;
        int nxt;
        s = 0;
        for (int i = 0; i < L; i++) begin
            logic signed [W-1:0] x;
            logic signed [W-1:0] y;
            x = va[i*W +: W];
            y = vb[i*W +: W];
            s += fix((int'(x) * int'(y)) >>> FR);
        end
        s = fix(s);
        nxt = fix((f ? 0 : m_acc) + s);
        if (l) begin
            exp_q.push_back(W'(nxt));
            m_acc = 0;
        end else begin
            m_acc = nxt;
        end
    endfunction

    function automatic logic [L*W-1:0] vec3(input logic [W-1:0] a0,
                                            input logic [W-1:0] a1,
                                            input logic [W-1:0] a2);
        return {a2, a1, a0};
    endfunction

    // Every handshaken result must be the oldest one the model predicts.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() != 0) e = exp_q.pop_front();
            else e = 'x;
            check("out_data", 32'(out_data), 32'(e));
        end
    end

    task automatic send(input logic [L*W-1:0] va, input logic [L*W-1:0] vb,
                        input logic f, input logic l, input bit rnd_ready);
        int n;
        bit done;
        n = 0;
        done = 0;
        in_a = va;
        in_b = vb;
        in_first = f;
        in_last = l;
        in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                model_beat(va, vb, f, l);
                done = 1;
            end else begin
                n++;
                if (n > 100) begin
                    check("accept_timeout", n, 0);
                    done = 1;
                end
            end
            @(posedge clk);
            #1;
            if (rnd_ready) out_ready = $urandom_range(0, 3) != 0;
        end
        in_valid = 1'b0;
    endtask

    task automatic lat_check(input string tag, input logic [31:0] exp);
        @(negedge clk);
        check({tag, "_v_t1"}, 32'(out_valid), 0);
        @(negedge clk);
        check({tag, "_v_t2"}, 32'(out_valid), 0);
        @(negedge clk);
        check({tag, "_v_t3"}, 32'(out_valid), 1);
        check({tag, "_data"}, 32'(out_data), exp);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_first = 1'b0;
        in_last = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1;

        send(vec3('h1000, 'h2000, 'h0800), vec3('h1000, 'h1000, 'h1000),
             1, 1, 0);
        lat_check("single", 'h3800);

        send(vec3('hF000, 'h1000, 'h0000), vec3('h1000, 'hE000, 'h1234),
             1, 1, 0);
        lat_check("negative", 'hD000);

        send(vec3('h1000, 'h2000, 'h0800), vec3('h1000, 'h1000, 'h1000),
             1, 0, 0);
        send(vec3('h1000, 'h2000, 'h0800), vec3('h1000, 'h1000, 'h1000),
             0, 1, 0);
        lat_check("two_beat", 'h7000);

        send(vec3('h7000, 'h7000, 'h7000), vec3('h2000, 'h2000, 'h2000),
             1, 1, 0);
        lat_check("overflow", OVF_EXP);
        drain();

        out_ready = 1'b0;
        for (int k = 0; k < 3; k++)
            send(vec3(W'('h1000 * (k + 1)), 0, 0), vec3('h1000, 0, 0),
                 1, 1, 0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 0);
            check("bp_out_valid", 32'(out_valid), 1);
            check("bp_hold", 32'(out_data), 'h1000);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(vec3('h4000, 0, 0), vec3('h1000, 0, 0), 1, 1, 0);
        drain();

        send(vec3('h0800, 'h0800, 0), vec3('h1000, 'h1000, 0), 1, 0, 0);
        rst = 1'b1;
        exp_q.delete();
        m_acc = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst2_out_valid", 32'(out_valid), 0);
        check("rst2_out_data", 32'(out_data), 0);
        check("rst2_in_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        send(vec3('h1000, 0, 0), vec3('h1000, 0, 0), 1, 1, 0);
        lat_check("after_rst", 'h1000);
        drain();

        for (int k = 0; k < 200; k++) begin
            logic [L*W-1:0] ra;
            logic [L*W-1:0] rb;
            for (int i = 0; i < L; i++) begin
                ra[i*W +: W] = W'($urandom);
                rb[i*W +: W] = W'($urandom);
            end
            send(ra, rb, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 2) == 0, 1);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk);
                    #1;
                    out_ready = $urandom_range(0, 3) != 0;
                end
            end
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
